// File: rtl/reg_file_dumper.sv
// Debug agent that walks an inclusive, wrap-around register range on a spare
// read port and streams {address, data} over valid/ready, keeping a running sum.
module reg_file_dumper #(
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  first_i,
    input  logic [4:0]  last_i,
    output logic [4:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_addr_o,
    output logic [31:0] out_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] sum_o
);

    typedef enum logic [1:0] {StIdle, StRead, StHold, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cur_q, cur_d;
    logic [4:0]  last_q, last_d;
    logic [4:0]  out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] sum_q, sum_d;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        sum_d      = sum_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cur_d   = first_i;
                    last_d  = last_i;
                    sum_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                // Capture here so later writes to the register do not leak into the word.
                out_data_d = rd_data_i;
                out_addr_d = cur_q;
                if ((SKIP_ZERO != 0) && (rd_data_i == '0)) begin
                    if (cur_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        cur_d = cur_q + 5'd1;
                    end
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    sum_d = sum_q + out_data_q;
                    if (cur_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        cur_d   = cur_q + 5'd1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            last_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            sum_q      <= sum_d;
        end
    end

    assign rd_addr_o   = cur_q;
    assign out_valid_o = (state_q == StHold);
    assign out_addr_o  = out_addr_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign sum_o       = sum_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench: one plain instance and one SKIP_ZERO instance share a
// register-file model; emitted words are compared to hand-derived lists.
module tb_reg_file_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [4:0]  first, last;
    logic        out_ready;
    logic [31:0] regs [32];

    logic [4:0]  rd_addr0, rd_addr1, addr0, addr1;
    logic [31:0] rd_data0, rd_data1, data0, data1, sum0, sum1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    logic        sel;
    logic [4:0]  o_rdaddr, o_addr;
    logic [31:0] o_data, o_sum;
    logic        o_valid, o_busy, o_done;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    assign o_rdaddr = sel ? rd_addr1 : rd_addr0;
    assign o_addr   = sel ? addr1 : addr0;
    assign o_data   = sel ? data1 : data0;
    assign o_sum    = sel ? sum1 : sum0;
    assign o_valid  = sel ? valid1 : valid0;
    assign o_busy   = sel ? busy1 : busy0;
    assign o_done   = sel ? done1 : done0;

    reg_file_dumper #(.SKIP_ZERO(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .first_i(first), .last_i(last),
        .rd_addr_o(rd_addr0), .rd_data_i(rd_data0), .out_valid_o(valid0),
        .out_ready_i(out_ready), .out_addr_o(addr0), .out_data_o(data0),
        .busy_o(busy0), .done_o(done0), .sum_o(sum0)
    );

    reg_file_dumper #(.SKIP_ZERO(1)) dut_skip (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .first_i(first), .last_i(last),
        .rd_addr_o(rd_addr1), .rd_data_i(rd_data1), .out_valid_o(valid1),
        .out_ready_i(out_ready), .out_addr_o(addr1), .out_data_o(data1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_mul16();
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 16);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 32; i++) regs[i] = '0;
    endtask

    // Called on a falling edge. rpat 0: ready always high; 1: ready every third cycle.
    task automatic run_dump(input string name, input logic s, input logic [4:0] f,
                            input logic [4:0] l, input int rpat, input int exp_cyc,
                            input logic extra);
        logic [4:0]  exp_a[$], got_a[$];
        logic [31:0] exp_d[$], got_d[$];
        logic [31:0] exp_sum;
        logic [4:0]  a, prev_a;
        logic [31:0] prev_d;
        int          n, done_cnt, done_cyc;
        logic        stalled, finished;

        exp_sum = '0;
        a = f;
        n = int'(5'(l - f)) + 1;
        for (int i = 0; i < n; i++) begin
            if (!(s && regs[a] == '0)) begin
                exp_a.push_back(a);
                exp_d.push_back(regs[a]);
                exp_sum = exp_sum + regs[a];
            end
            a = a + 5'd1;
        end

        sel = s;
        first = f;
        last = l;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        done_cnt = 0;
        done_cyc = 0;
        stalled = 1'b0;
        finished = 1'b0;
        prev_a = '0;
        prev_d = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 1) begin
                first = ~f;
                last = ~l;
            end
            if (extra && cyc == 5) begin
                first = 5'd7;
                last = 5'd8;
                if (s) start1 = 1'b1; else start0 = 1'b1;
            end
            out_ready = (rpat == 0) ? 1'b1 : (cyc % 3 == 2);
            #1;
            if (o_valid) begin
                if (stalled) begin
                    check({name, " stable_addr"}, 32'(o_addr), 32'(prev_a));
                    check({name, " stable_data"}, o_data, prev_d);
                end
                if (out_ready) begin
                    got_a.push_back(o_addr);
                    got_d.push_back(o_data);
                end else if (rpat == 1) begin
                    // Late write to the register being held must not disturb the word.
                    regs[o_addr] = ~regs[o_addr];
                end
                stalled = !out_ready;
                prev_a = o_addr;
                prev_d = o_data;
            end else begin
                stalled = 1'b0;
            end
            if (done_cnt > 0 && (cyc == done_cyc + 1 || cyc == done_cyc + 2))
                check({name, " busy_after_done"}, 32'(o_busy), 32'd0);
            if (o_done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
                if (extra) begin
                    if (s) start1 = 1'b1; else start0 = 1'b1;
                end
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
        end

        check({name, " finished"}, 32'(finished), 32'd1);
        check({name, " done_pulses"}, 32'(done_cnt), 32'd1);
        if (exp_cyc >= 0) check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        check({name, " word_count"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), 32'(got_a[i]), 32'(exp_a[i]));
            check($sformatf("%s data[%0d]", name, i), got_d[i], exp_d[i]);
        end
        check({name, " sum"}, o_sum, exp_sum);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        first = '0;
        last = '0;
        out_ready = 1'b0;
        sel = 1'b0;
        fill_mul16();
        repeat (2) @(negedge clk);
        #1;
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset rd_addr", 32'(o_rdaddr), 32'd0);
        check("reset sum", o_sum, 32'd0);
        check("reset data", o_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_dump("full", 1'b0, 5'd0, 5'd31, 0, 64, 1'b0);
        check("full sum_7936", o_sum, 32'd7936);

        run_dump("wrap", 1'b0, 5'd30, 5'd1, 1, -1, 1'b0);
        fill_mul16();

        regs[5] = 32'hDEADBEEF;
        run_dump("single", 1'b0, 5'd5, 5'd5, 0, 2, 1'b0);
        check("single sum_deadbeef", o_sum, 32'hDEADBEEF);

        fill_zero();
        regs[3] = 32'd7;
        regs[9] = 32'd1;
        run_dump("skip", 1'b1, 5'd0, 5'd15, 0, 18, 1'b0);
        check("skip sum_8", o_sum, 32'd8);

        fill_zero();
        run_dump("allzero", 1'b1, 5'd0, 5'd31, 0, 32, 1'b0);

        // Reset while holding the second word of a dump.
        fill_mul16();
        sel = 1'b0;
        first = 5'd4;
        last = 5'd20;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst valid", 32'(o_valid), 32'd1);
        check("pre_rst addr", 32'(o_addr), 32'd5);
        check("pre_rst sum", o_sum, 32'd64);
        #2;
        rst = 1'b1;
        #1;
        check("rst valid", 32'(o_valid), 32'd0);
        check("rst addr", 32'(o_addr), 32'd0);
        check("rst data", o_data, 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst sum", o_sum, 32'd0);
        check("rst rd_addr", 32'(o_rdaddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("post_rst idle_busy", 32'(o_busy), 32'd0);
            check("post_rst idle_done", 32'(o_done), 32'd0);
        end
        @(negedge clk);

        run_dump("restart", 1'b0, 5'd0, 5'd31, 0, 64, 1'b1);
        check("restart sum_7936", o_sum, 32'd7936);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_file_dumper.md
# reg_file_dumper

Sequential reader for the 32×32 register file's combinational read port. On a start pulse it walks an inclusive, wrap-around register address range and drives one read address per register. It captures each returned word and streams it out as {address, data} over a valid/ready handshake. It sits beside the register file as a debug/state-dump agent on a spare read port, and keeps a running wrap-around sum of emitted words for quick bench comparison.

## Interface
Parameters:
- SKIP_ZERO, default 0, 1 = registers whose read data is 0 are not emitted (still counted as visited)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a dump; sampled only in IDLE
- first_i  in  5  first register address, captured on accepted start
- last_i  in  5  last register address (inclusive), captured on accepted start
- rd_addr_o  out  5  read address to register file read port
- rd_data_i  in  32  combinational read data for rd_addr_o
- out_valid_o  out  1  out_addr_o/out_data_o hold a word
- out_ready_i  in  1  consumer accepts word when out_valid_o & out_ready_i
- out_addr_o  out  5  address of emitted word
- out_data_o  out  32  emitted register value
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at dump completion
- sum_o  out  32  modulo-2^32 sum of all words emitted in current/last dump

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: start_i=1 → capture cur=first_i, last=last_i, clear sum_o → READ. start_i=0 → stay.
- READ: rd_addr_o=cur; rd_data_i registered into out_data_o, cur into out_addr_o.
  - SKIP_ZERO=1 and rd_data_i==0: no emit; if cur==last → DONE, else cur=cur+1 → READ.
  - Otherwise → HOLD.
- HOLD: out_valid_o=1; out_addr_o/out_data_o stable until handshake.
  - On handshake: sum_o += out_data_o; if cur==last → DONE, else cur=cur+1 → READ.
  - No handshake → stay.
- DONE: done_o=1 for exactly this cycle → IDLE.
- Range arithmetic is 5-bit modulo 32. cur increments 31→0.
  - Register count = ((last−first) mod 32)+1.
  - first==last → 1 register; first=0,last=31 → 32; first=30,last=1 → 30,31,0,1.
- start_i while busy_o=1 is ignored; first_i/last_i changes after capture have no effect.
- rd_addr_o = cur in all states (IDLE shows last value of cur).
- Block never writes the register file. A register written by another agent between its READ cycle and emission still reports the READ-cycle value.

## Timing
- Reset values: state IDLE, cur 0, rd_addr_o 0, out_valid_o 0, out_addr_o 0, out_data_o 0, busy_o 0, done_o 0, sum_o 0.
- Reset mid-dump: immediate return to reset values; no done_o, no further output.
- Start accepted at edge N → READ during cycle N..N+1 → out_valid_o first high after edge N+1 (2-edge latency).
- Throughput: one word per 2 cycles with out_ready_i held high. 32-register dump with ready=1: 64 cycles start→last handshake, done_o in the following cycle.
- A skipped word costs 1 cycle (READ only).
- out_valid_o never drops without a handshake; no combinational path from out_ready_i to any output.
- sum_o updates the cycle after the handshake edge; it holds its value after DONE until the next accepted start.
- start_i high in the DONE cycle is ignored; a start is accepted in IDLE one cycle later at the earliest.

## Test plan
- Regs r[i]=i*16, start with first=0,last=31, ready=1 → 32 words addr 0..31 in order, data i*16, done_o one pulse, sum_o=7936, busy_o low after DONE.
- first=30,last=1, ready toggling 1-in-3 → words for addresses 30,31,0,1 only, data stable while valid&!ready, no drops or duplicates.
- first=last=5, r5=0xDEADBEEF → exactly one word (5,0xDEADBEEF), sum_o=0xDEADBEEF.
- SKIP_ZERO=1, only r3=7 and r9=1 nonzero, range 0..15 → two words (3,7),(9,1), sum_o=8, done_o pulses.
- SKIP_ZERO=1, all-zero range 0..31 → no out_valid_o, done_o after 32 READ cycles.
- rst_i asserted while in HOLD → outputs at reset values asynchronously; start pulse after release during active dump ignored; second start pulse in IDLE produces a full new dump.
